// File: rtl/state_trace_fifo.sv
// rtl/state_trace_fifo.sv - state-change trace FIFO with valid/ready drain port.
// Define TRACE_DWELL_EN to record per-entry dwell counts; otherwise rd_dwell is tied to 0.
module state_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 5
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [2:0]             s_in,
  input  logic                   clr,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [2:0]             rd_state,
  output logic [DW-1:0]          rd_dwell,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    prev_s_q;
  logic          armed_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic [2:0]    mem_state_q [DEPTH];
  logic          change, pop, push, drop;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign rd_state = rd_valid ? mem_state_q[rd_ptr_q] : 3'd0;

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign change = armed_q && (s_in != prev_s_q);
  assign pop    = rd_valid && rd_ready;
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      prev_s_q <= 3'd0;
      armed_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      armed_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (!armed_q || change) prev_s_q <= s_in;
      armed_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push) mem_state_q[wr_ptr_q] <= s_in;
  end

`ifdef TRACE_DWELL_EN
  logic [DW-1:0] dwell_cnt_q;
  logic [DW-1:0] mem_dwell_q [DEPTH];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      dwell_cnt_q <= '0;
    end else if (!clr) begin
      if (!armed_q || change)   dwell_cnt_q <= DW'(1);
      else if (dwell_cnt_q != '1) dwell_cnt_q <= dwell_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && push) mem_dwell_q[wr_ptr_q] <= dwell_cnt_q;
  end

  assign rd_dwell = rd_valid ? mem_dwell_q[rd_ptr_q] : '0;
`else
  assign rd_dwell = '0;
`endif

endmodule

// File: tb/tb_state_trace_fifo.sv
// tb/tb_state_trace_fifo.sv - randomized and directed checks of state_trace_fifo against a queue model.
module tb_state_trace_fifo;
  localparam int DEPTH = 8;
  localparam int DW    = 5;
  localparam int DMAX  = 31;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [2:0] s_in = 3'd5;
  logic       clr = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [2:0] rd_state;
  logic [4:0] rd_dwell;
  logic [3:0] count;
  logic       full;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  state_trace_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .res(res), .s_in(s_in), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_state(rd_state), .rd_dwell(rd_dwell),
    .count(count), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  wire [14:0] dut_vec = {rd_valid, rd_state, rd_dwell, count, full, ovf};

  typedef struct packed {
    logic [2:0] st;
    logic [4:0] dw;
  } ent_t;

  ent_t       m_q[$];
  bit         m_armed;
  logic [2:0] m_prev;
  int         m_dwell;
  bit         m_ovf;

`ifdef TRACE_DWELL_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  function automatic void model_reset();
    m_q.delete();
    m_armed = 0;
    m_prev  = 3'd0;
    m_dwell = 0;
    m_ovf   = 0;
  endfunction

  function automatic void model_edge();
    bit   do_pop, do_change;
    ent_t e;
    if (!res) begin
      model_reset();
      return;
    end
    if (clr) begin
      m_q.delete();
      m_ovf   = 0;
      m_armed = 0;
      return;
    end
    do_pop    = (m_q.size() != 0) && rd_ready;
    do_change = m_armed && (s_in != m_prev);
    e.st = s_in;
    e.dw = 5'(m_dwell);
    if (do_pop) void'(m_q.pop_front());
    if (do_change) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1;
    end
    if (!m_armed || do_change) m_dwell = 1;
    else if (m_dwell < DMAX) m_dwell = m_dwell + 1;
    if (!m_armed || do_change) m_prev = s_in;
    m_armed = 1;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [2:0] st;
    logic [4:0] dw;
    int n;
    n  = m_q.size();
    st = (n != 0) ? m_q[0].st : 3'd0;
    dw = (n != 0 && DWELL_EN) ? m_q[0].dw : 5'd0;
    return {n != 0, st, dw, 4'(n), n == DEPTH, m_ovf};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hard_reset();
    res = 1'b0;
    #1;
    model_reset();
    res = 1'b1;
    clr = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic push_changes(input int n);
    for (int i = 0; i < n; i++) begin
      s_in = s_in + 3'd1;
      step();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (dut_vec !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
    model_reset();
    res = 1'b1;
  endtask

  task automatic test_first_entry();
    s_in = 3'd3;
    step();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL arm_no_push: count got %0d want 0", count);
    end
    for (int i = 0; i < 3; i++) step();
    s_in = 3'd5;
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_state !== 3'd5 || rd_dwell !== (DWELL_EN ? 5'd4 : 5'd0) || count !== 4'd1) begin
      errors++;
      $display("FAIL first_entry: got v=%b s=%0d d=%0d c=%0d want v=1 s=5 d=%0d c=1",
               rd_valid, rd_state, rd_dwell, count, DWELL_EN ? 4 : 0);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL first_entry_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_overflow();
    logic [2:0] seq [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    hard_reset();
    s_in = 3'd0;
    step();
    for (int i = 0; i < 9; i++) begin
      s_in = seq[i];
      step();
    end
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got c=%0d f=%b o=%b want c=8 f=1 o=1", count, full, ovf);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_state !== seq[i] || rd_dwell !== (DWELL_EN ? 5'd1 : 5'd0) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL drain_%0d: got s=%0d d=%0d vec=%h want s=%0d vec=%h",
                 i, rd_state, rd_dwell, dut_vec, seq[i], exp_vec());
      end
      step();
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_state !== 3'd0 || count !== 4'd0) begin
      errors++;
      $display("FAIL drain_empty: got v=%b s=%0d c=%0d want 0 0 0", rd_valid, rd_state, count);
    end
  endtask

  task automatic test_full_push_pop();
    hard_reset();
    s_in = 3'd0;
    step();
    push_changes(8);
    s_in = 3'd1;
    rd_ready = 1'b1;
    step();
    checks++;
    if (count !== 4'd8 || ovf !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_push_pop: got c=%0d o=%b want c=8 o=0", count, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fpp_drain_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 7) begin
        checks++;
        if (rd_state !== 3'd1 || rd_dwell !== (DWELL_EN ? 5'd1 : 5'd0)) begin
          errors++;
          $display("FAIL fpp_last: got s=%0d d=%0d want s=1", rd_state, rd_dwell);
        end
      end
      step();
    end
  endtask

  task automatic test_dwell_saturate();
    hard_reset();
    s_in = 3'd2;
    for (int i = 0; i < 40; i++) step();
    s_in = 3'd6;
    step();
    checks++;
    if (rd_state !== 3'd6 || rd_dwell !== (DWELL_EN ? 5'd31 : 5'd0)) begin
      errors++;
      $display("FAIL dwell_sat: got s=%0d d=%0d want s=6 d=%0d", rd_state, rd_dwell, DWELL_EN ? 31 : 0);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL dwell_sat_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_clear();
    hard_reset();
    s_in = 3'd0;
    step();
    push_changes(9);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_ready = 1'b0;
    checks++;
    if (count !== 4'd3 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL pre_clr: got c=%0d o=%b want c=3 o=1", count, ovf);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (count !== 4'd0 || ovf !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr: got c=%0d o=%b v=%b want 0 0 0", count, ovf, rd_valid);
    end
    s_in = s_in + 3'd3;
    step();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL clr_rearm: got c=%0d want 0", count);
    end
    s_in = s_in + 3'd1;
    step();
    checks++;
    if (dut_vec !== exp_vec() || count !== 4'd1) begin
      errors++;
      $display("FAIL clr_after: got %h want %h", dut_vec, exp_vec());
    end
    push_changes(10);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_ready = 1'b0;
    checks++;
    if (count !== 4'd3 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL pre_res: got c=%0d o=%b want c=3 o=1", count, ovf);
    end
    res = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 15'd0) begin
      errors++;
      $display("FAIL async_res: got %h want 0", dut_vec);
    end
    model_reset();
    res = 1'b1;
    step();
    checks++;
    if (count !== 4'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL res_rearm: got c=%0d v=%b want 0 0", count, rd_valid);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    hard_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) s_in = 3'($urandom_range(0, 7));
      rd_ready = ($urandom_range(0, 3) == 0);
      clr      = ($urandom_range(0, 59) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_entry();
    test_overflow();
    test_full_push_pop();
    test_dwell_saturate();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
